instr_fetch_unit: RTL and testbench

//  Front-end stage directly upstream of mainMemory: owns the program counter and drives the

---
 rtl/instr_fetch_unit_pkg.sv | 25 ++
 rtl/instr_fetch_unit_fetch_wait_counter.sv | 42 ++++
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 tb/tb_instr_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//  - state_e        : fetch FSM encodings
//  - DEF_*          : default widths and reset PC
//  - long_opcode_bit: opcode bit that marks a 2-byte instruction
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRdOp  = 2'd1,
    StRdArg = 2'd2,
    StValid = 2'd3
  } state_e;

  localparam int unsigned DEF_ADDR_W   = 8;
  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_RESET_PC = 0;

  // The opcode MSB flags a 2-byte instruction.
  function automatic int unsigned long_opcode_bit(input int unsigned data_w);
    return data_w - 1;
  endfunction

  localparam int unsigned LONG_OPCODE_BIT = DEF_DATA_W - 1;

endpackage

// File: rtl/instr_fetch_unit_fetch_wait_counter.sv
// Memory read wait counter for the fetch unit.
//  clk    : rising-edge clock
//  reset  : asynchronous active-low reset
//  clear  : drop any partial count (redirect)
//  start  : high for every cycle a memory read is being held
//  done   : high on the cycle whose closing edge samples memData
module instr_fetch_unit_fetch_wait_counter #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic start,
  output logic done
);

  localparam int unsigned CntW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(READ_LATENCY - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign done = start && (cnt_q == LastCnt);

  // Counter re-arms to zero on completion so back-to-back reads need no extra cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d = done ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the memory read port and hands
// 1- or 2-byte instructions to decode over a valid/ready handshake.
//  clk, reset (async, active-low)
//  run            : allow new fetches
//  pc_load/target : redirect, highest priority
//  address/memRead/memData : memory read port (address always equals pc)
//  instr_valid/ready/opcode/operand/pc : decode handshake
//  pc             : next byte to fetch
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W       = DEF_ADDR_W,
  parameter int unsigned       DATA_W       = DEF_DATA_W,
  parameter int unsigned       READ_LATENCY = 1,
  parameter logic [ADDR_W-1:0] RESET_PC     = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic [ADDR_W-1:0] address,
  output logic              memRead,
  input  logic [DATA_W-1:0] memData,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_operand,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc
);

  localparam int unsigned LongBit = long_opcode_bit(DATA_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic              reading;
  logic              wait_done;

  assign reading = (state_q == StRdOp) || (state_q == StRdArg);

  instr_fetch_unit_fetch_wait_counter #(
    .READ_LATENCY(READ_LATENCY)
  ) u_wait (
    .clk  (clk),
    .reset(reset),
    .clear(pc_load),
    .start(reading),
    .done (wait_done)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_pc_q <= RESET_PC;
      opcode_q   <= '0;
      operand_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
    end
  end

  // Next state. A redirect overrides everything, including a coincident accept.
  always_comb begin
    state_d = state_q;
    if (pc_load) begin
      state_d = run ? StRdOp : StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (run) state_d = StRdOp;
        StRdOp:  if (wait_done) state_d = memData[LongBit] ? StRdArg : StValid;
        StRdArg: if (wait_done) state_d = StValid;
        StValid: if (instr_ready) state_d = run ? StRdOp : StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath next values: capture bytes on the sampling edge and advance pc.
  always_comb begin
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    if (pc_load) begin
      pc_d = pc_target;
    end else if (wait_done && state_q == StRdOp) begin
      opcode_d   = memData;
      operand_d  = '0;
      instr_pc_d = pc_q;
      pc_d       = pc_q + 1'b1;
    end else if (wait_done && state_q == StRdArg) begin
      operand_d = memData;
      pc_d      = pc_q + 1'b1;
    end
  end

  // Outputs are decoded from registered state, so reset drops memRead at once.
  always_comb begin
    address       = pc_q;
    pc            = pc_q;
    memRead       = reading;
    instr_valid   = (state_q == StValid);
    instr_opcode  = opcode_q;
    instr_operand = operand_q;
    instr_pc      = instr_pc_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       pc_load;
  logic [7:0] pc_target;
  logic [7:0] address;
  logic       memRead;
  logic [7:0] memData;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic [7:0] instr_pc;
  logic [7:0] pc;

  logic [7:0] mem [256];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign memData = mem[address];

  instr_fetch_unit #(
    .ADDR_W      (8),
    .DATA_W      (8),
    .READ_LATENCY(1),
    .RESET_PC    (8'h00)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .pc_load      (pc_load),
    .pc_target    (pc_target),
    .address      (address),
    .memRead      (memRead),
    .memData      (memData),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_operand(instr_operand),
    .instr_pc     (instr_pc),
    .pc           (pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h12;
    mem[8'h01] = 8'hC4;
    mem[8'h02] = 8'h7F;
    mem[8'h03] = 8'h01;
    mem[8'h04] = 8'h83;
    mem[8'h05] = 8'h55;
    mem[8'h40] = 8'h21;
    mem[8'hFF] = 8'h80;

    reset       = 1'b0;
    run         = 1'b1;
    pc_load     = 1'b0;
    pc_target   = 8'h00;
    instr_ready = 1'b1;

    // 1. reset held two cycles with run=1
    repeat (2) step();
    chk("rst_memRead", memRead, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_address", address, 8'h00);
    chk("rst_opcode", instr_opcode, 8'h00);
    chk("rst_operand", instr_operand, 8'h00);
    chk("rst_instr_pc", instr_pc, 8'h00);
    reset = 1'b1;
    step();
    chk("t1_memRead", memRead, 1);
    chk("t1_address", address, 8'h00);

    // 2. 1-byte instruction at 0
    step();
    chk("t2_valid", instr_valid, 1);
    chk("t2_opcode", instr_opcode, 8'h12);
    chk("t2_operand", instr_operand, 8'h00);
    chk("t2_instr_pc", instr_pc, 8'h00);
    chk("t2_pc", pc, 8'h01);
    chk("t2_memRead", memRead, 0);
    step();
    chk("t2_next_memRead", memRead, 1);
    chk("t2_next_address", address, 8'h01);

    // 3. 2-byte instruction at 1
    step();
    chk("t3_mid_valid", instr_valid, 0);
    chk("t3_mid_address", address, 8'h02);
    chk("t3_mid_memRead", memRead, 1);
    step();
    chk("t3_valid", instr_valid, 1);
    chk("t3_opcode", instr_opcode, 8'hC4);
    chk("t3_operand", instr_operand, 8'h7F);
    chk("t3_instr_pc", instr_pc, 8'h01);
    chk("t3_pc", pc, 8'h03);

    // 4. stall for five cycles
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_valid", instr_valid, 1);
      chk("t4_hold_opcode", instr_opcode, 8'hC4);
      chk("t4_hold_operand", instr_operand, 8'h7F);
      chk("t4_hold_pc", pc, 8'h03);
      chk("t4_hold_memRead", memRead, 0);
    end
    instr_ready = 1'b1;
    step();
    chk("t4_acc_valid", instr_valid, 0);
    chk("t4_acc_memRead", memRead, 1);
    chk("t4_acc_address", address, 8'h03);
    step();
    chk("t4_next_opcode", instr_opcode, 8'h01);
    chk("t4_next_instr_pc", instr_pc, 8'h03);
    chk("t4_next_pc", pc, 8'h04);

    // 5. redirect during RD_ARG
    step();
    chk("t5_rdop_address", address, 8'h04);
    step();
    chk("t5_rdarg_address", address, 8'h05);
    chk("t5_rdarg_valid", instr_valid, 0);
    pc_load   = 1'b1;
    pc_target = 8'h40;
    step();
    pc_load = 1'b0;
    chk("t5_redir_valid", instr_valid, 0);
    chk("t5_redir_address", address, 8'h40);
    chk("t5_redir_memRead", memRead, 1);
    step();
    chk("t5_valid", instr_valid, 1);
    chk("t5_opcode", instr_opcode, 8'h21);
    chk("t5_operand", instr_operand, 8'h00);
    chk("t5_instr_pc", instr_pc, 8'h40);
    chk("t5_pc", pc, 8'h41);

    // 6. redirect coinciding with accept, 2-byte instruction wrapping at 0xFF
    mem[8'h00] = 8'h05;
    pc_load    = 1'b1;
    pc_target  = 8'hFF;
    step();
    pc_load = 1'b0;
    chk("t6_valid0", instr_valid, 0);
    chk("t6_address0", address, 8'hFF);
    step();
    chk("t6_wrap_address", address, 8'h00);
    chk("t6_wrap_memRead", memRead, 1);
    step();
    chk("t6_valid", instr_valid, 1);
    chk("t6_opcode", instr_opcode, 8'h80);
    chk("t6_operand", instr_operand, 8'h05);
    chk("t6_instr_pc", instr_pc, 8'hFF);
    chk("t6_pc", pc, 8'h01);

    // run=0 at acceptance parks the unit in IDLE
    run = 1'b0;
    step();
    chk("idle_valid", instr_valid, 0);
    chk("idle_memRead", memRead, 0);
    step();
    chk("idle_stay_memRead", memRead, 0);
    chk("idle_stay_pc", pc, 8'h01);

    // Reset asserted mid-read takes effect without a clock edge
    run = 1'b1;
    step();
    chk("mid_memRead", memRead, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_memRead", memRead, 0);
    chk("async_pc", pc, 8'h00);
    chk("async_valid", instr_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
